display_scanner: RTL
====================

DISPLAY_SCANNER -- requirements
Module: display_scanner

Interface
REQ-001 Parameter NUM_CH, default 8: number of result channels scanned (2..16).
REQ-002 Parameter DATA_W, default 8: width of each channel value.
REQ-003 Parameter DWELL_CYCLES, default 12500: clk cycles each channel is shown in auto mode (>=2).
REQ-004 Parameter SNAPSHOT, default 1: 1 = latch the value when the channel is selected; 0 = track the selected channel live.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst  input  1  synchronous, active-low reset.
REQ-007 ch_data  input  NUM_CH*DATA_W  flattened channel values; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-008 ch_enable  input  NUM_CH  per-channel scan mask; bit k=1 includes channel k.
REQ-009 mode  input  1  0 = auto scan on dwell timer; 1 = manual scan on step.
REQ-010 step  input  1  single-cycle advance request, used in manual mode only.
REQ-011 hold  input  1  freeze selection and dwell timer while high.
REQ-012 disp_value  output  DATA_W  value presented to the seven-segment driver.
REQ-013 disp_idx  output  $clog2(NUM_CH)  currently selected channel.
REQ-014 disp_update  output  1  one-cycle pulse on every accepted advance.
REQ-015 disp_blank  output  1  high when ch_enable is all zero; driver blanks the digits.

Function
REQ-016 Dwell counter SHALL count 0..DWELL_CYCLES-1 and wrap; tick SHALL assert in the cycle the count equals DWELL_CYCLES-1.
REQ-017 Advance event: mode=0 and tick; or mode=1 and step=1. Ticks SHALL be ignored in manual mode and step in auto mode.
REQ-018 hold=1 SHALL suppress advance events and freeze the counter; hold SHALL win over a simultaneous tick or step.
REQ-019 On an advance, disp_idx SHALL become the next enabled channel above disp_idx, searching upward and wrapping from NUM_CH-1 to 0.
REQ-020 If only the current channel is enabled, disp_idx SHALL be unchanged and disp_update SHALL still pulse.
REQ-021 If the current channel's enable bit is 0 while others are enabled, the block SHALL advance on the next edge regardless of tick, step or hold, and disp_update SHALL pulse.
REQ-022 If ch_enable is all zero: disp_blank=1 (registered, one-cycle latency); disp_idx held; no disp_update; counter keeps running.
REQ-023 disp_update SHALL be registered and asserted in the same cycle disp_idx takes its new value.
REQ-024 SNAPSHOT=1: disp_value SHALL load ch_data[new idx] on the advance edge and hold until the next advance.
REQ-025 SNAPSHOT=0: disp_value SHALL equal the channel at disp_idx, registered with one-cycle latency.
REQ-026 A change of mode SHALL reset the dwell counter to 0 on the next edge.
REQ-027 No arithmetic overflow: counter width is $clog2(DWELL_CYCLES); index wrap is explicit, not modulo-2^n, for non-power-of-two NUM_CH.

Reset
REQ-028 rst=0 at a rising edge SHALL set counter=0, disp_idx=0, disp_value=0, disp_update=0 and disp_blank=0, overriding all other inputs including mid-dwell.
REQ-029 In the first cycle after reset, REQ-021 and REQ-022 SHALL apply normally (e.g. channel 0 disabled -> advance on the next edge).

Structure
REQ-030 Shared package SHALL hold the default constants for NUM_CH, DATA_W and DWELL_CYCLES, and the mode encoding (AUTO=0, MANUAL=1).
REQ-031 Sub-module dwell_timer (counter, tick, clear input, freeze input) SHALL be used; next-enabled search and selection SHALL stay in display_scanner.

Verification
REQ-032 NUM_CH=8, DWELL_CYCLES=4, all enabled, auto mode -> disp_idx 0,1,...,7,0 changes every 4 cycles; disp_update pulses 8 times in 32 cycles.
REQ-033 ch_enable=8'b1000_0100, idx=2, tick -> idx=7; next tick -> idx=2 (wrap); disp_value follows ch_data[7], then ch_data[2].
REQ-034 Manual mode, step pulses with hold=1 on the 2nd of 3 -> exactly 2 advances; ticks cause no change.
REQ-035 SNAPSHOT=1, ch_data[0] changes 0x11->0x22 mid-dwell -> disp_value stays 0x11; SNAPSHOT=0 -> disp_value shows 0x22 one cycle later.
REQ-036 ch_enable=0 -> disp_blank=1 the next cycle, no disp_update; enable=8'h10 -> advance to idx=4 on the next edge, disp_blank=0.
REQ-037 rst=0 asserted mid-dwell at idx=5 -> next cycle idx=0, disp_value=0, counter=0; NUM_CH=5 wrap from idx 4 goes to 0.

Source files
------------

// File: rtl/display_scanner_pkg.sv
// Shared constants and mode encoding for the display scanner.
package display_scanner_pkg;

    localparam int unsigned DEF_NUM_CH       = 8;
    localparam int unsigned DEF_DATA_W       = 8;
    localparam int unsigned DEF_DWELL_CYCLES = 12500;

    typedef enum logic {
        MODE_AUTO   = 1'b0,
        MODE_MANUAL = 1'b1
    } scan_mode_e;

endpackage

// File: rtl/display_scanner_dwell.sv
// Dwell timer: counts 0..DWELL_CYCLES-1 and wraps; tick marks the last count.
module dwell_timer
    import display_scanner_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES = DEF_DWELL_CYCLES,
    localparam int unsigned CNT_W       = $clog2(DWELL_CYCLES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             freeze,
    output logic             tick,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL_CYCLES - 1);

    logic [CNT_W-1:0] count_q, count_d;

    // Next count: clear beats freeze; wrap explicitly at the last count.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (!freeze) begin
            count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick  = (count_q == LAST);
    assign count = count_q;

endmodule

// File: rtl/display_scanner.sv
// Multiplexed display scanner: steps through enabled result channels on a
// dwell timer (auto) or on step pulses (manual) and presents one value.
module display_scanner
    import display_scanner_pkg::*;
#(
    parameter int unsigned NUM_CH       = DEF_NUM_CH,
    parameter int unsigned DATA_W       = DEF_DATA_W,
    parameter int unsigned DWELL_CYCLES = DEF_DWELL_CYCLES,
    parameter bit          SNAPSHOT     = 1'b1,
    localparam int unsigned IDX_W       = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic [NUM_CH-1:0]        ch_enable,
    input  logic                     mode,
    input  logic                     step,
    input  logic                     hold,
    output logic [DATA_W-1:0]        disp_value,
    output logic [IDX_W-1:0]         disp_idx,
    output logic                     disp_update,
    output logic                     disp_blank
);

    localparam int unsigned CNT_W = $clog2(DWELL_CYCLES);

    logic [DATA_W-1:0] ch_arr [NUM_CH];
    scan_mode_e        mode_q;
    scan_mode_e        mode_in;
    logic              tick;
    logic [CNT_W-1:0]  count_unused;
    logic              any_en, cur_en, req, force_adv, adv;
    logic [IDX_W-1:0]  idx_q, idx_d, next_idx;
    logic [DATA_W-1:0] value_q, value_d;
    logic              update_q, blank_q;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
        assign ch_arr[k] = ch_data[k*DATA_W +: DATA_W];
    end

    assign mode_in = scan_mode_e'(mode);

    dwell_timer #(
        .DWELL_CYCLES(DWELL_CYCLES)
    ) u_dwell (
        .clk   (clk),
        .rst   (rst),
        .clear (mode_in != mode_q),
        .freeze(hold),
        .tick  (tick),
        .count (count_unused)
    );

    // First enabled channel above cur, wrapping explicitly; k = NUM_CH lands
    // back on cur, so a lone enabled channel re-selects itself.
    function automatic logic [IDX_W-1:0] next_enabled(
        input logic [IDX_W-1:0]  cur,
        input logic [NUM_CH-1:0] en
    );
        logic [IDX_W-1:0] result;
        logic             found;
        int unsigned      cand;
        result = cur;
        found  = 1'b0;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            cand = int'(cur) + k;
            if (cand >= NUM_CH) cand = cand - NUM_CH;
            if (!found && en[IDX_W'(cand)]) begin
                result = IDX_W'(cand);
                found  = 1'b1;
            end
        end
        return result;
    endfunction

    // Advance decision: a disabled current channel forces a move even under hold.
    always_comb begin
        any_en    = |ch_enable;
        cur_en    = ch_enable[idx_q];
        req       = ((mode_in == MODE_AUTO) && tick) ||
                    ((mode_in == MODE_MANUAL) && step);
        force_adv = any_en && !cur_en;
        adv       = any_en && (force_adv || (req && !hold));
        next_idx  = next_enabled(idx_q, ch_enable);
        idx_d     = adv ? next_idx : idx_q;
        if (SNAPSHOT) begin
            value_d = adv ? ch_arr[next_idx] : value_q;
        end else begin
            value_d = ch_arr[idx_q];
        end
    end

    // Output and mode-tracking registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            idx_q    <= '0;
            value_q  <= '0;
            update_q <= 1'b0;
            blank_q  <= 1'b0;
            mode_q   <= MODE_AUTO;
        end else begin
            idx_q    <= idx_d;
            value_q  <= value_d;
            update_q <= adv;
            blank_q  <= !any_en;
            mode_q   <= mode_in;
        end
    end

    assign disp_value  = value_q;
    assign disp_idx    = idx_q;
    assign disp_update = update_q;
    assign disp_blank  = blank_q;

endmodule
